// File: rtl/fm_demod_pkg.sv
// fm_demod_pkg: shared widths, limits and saturation helper for the FM demod chain
package fm_demod_pkg;
  localparam int LAG_MAX = 8;
  localparam int SAT_W = 66;
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction
  function automatic int diff_w(input int w);
    return 2 * w + 1;
  endfunction
  // clamps v to the signed range of a w-bit value; callers keep the low w bits
  function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] v, input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    lo = ~hi;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/fm_discriminator_if.sv
// fm_disc_if: sample-in / demod-out bundle of the FM discriminator
interface fm_disc_if #(parameter int WIDTH = 16, parameter int OUT_WIDTH = 16);
  logic clear_i;
  logic valid_i;
  logic signed [WIDTH-1:0] real_i;
  logic signed [WIDTH-1:0] imag_i;
  logic valid_o;
  logic signed [OUT_WIDTH-1:0] demod_o;
  logic sat_o;
  modport master(output clear_i, valid_i, real_i, imag_i, input valid_o, demod_o, sat_o);
  modport slave(input clear_i, valid_i, real_i, imag_i, output valid_o, demod_o, sat_o);
endinterface

// File: rtl/fm_disc_history.sv
// fm_disc_history: valid-gated LAG-deep I/Q delay line with priming counter
module fm_disc_history
  import fm_demod_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LAG = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic valid,
  input  logic signed [WIDTH-1:0] re,
  input  logic signed [WIDTH-1:0] im,
  output logic signed [WIDTH-1:0] re_d,
  output logic signed [WIDTH-1:0] im_d,
  output logic primed
);
  localparam int CW = $clog2(LAG_MAX + 1);
  logic signed [WIDTH-1:0] hre [LAG];
  logic signed [WIDTH-1:0] him [LAG];
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hre <= '{default: '0};
      him <= '{default: '0};
      cnt <= '0;
    end else if (valid) begin
      hre[0] <= re;
      him[0] <= im;
      for (int i = 1; i < LAG; i++) begin
        hre[i] <= hre[i-1];
        him[i] <= him[i-1];
      end
      cnt <= primed ? cnt : cnt + 1'b1;
    end
  end
  assign primed = cnt == CW'(LAG);
  assign re_d = hre[LAG-1];
  assign im_d = him[LAG-1];
endmodule

// File: rtl/fm_discriminator.sv
// fm_discriminator: 3-stage Im{x[n]*conj(x[n-LAG])} discriminator, shift and saturate
// FM_DISC_ROUND_EN adds a round-half-up bias before the shift.
module fm_discriminator
  import fm_demod_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OUT_WIDTH = 16,
  parameter int LAG = 1,
  parameter int SHIFT = 15
) (
  input logic clk,
  input logic rst,
  fm_disc_if.slave bus
);
  localparam int PW = prod_w(WIDTH);
  localparam int DW = diff_w(WIDTH);
`ifdef FM_DISC_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int RW = DW + RND;
  localparam logic signed [RW-1:0] BIAS = (RND == 1 && SHIFT > 0) ? RW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  logic signed [WIDTH-1:0] re_d, im_d, s1_a, s1_b, s1_ar, s1_br;
  logic primed, s1_v, s2_v, valid, sat;
  logic signed [PW-1:0] s2_p1, s2_p2;
  logic signed [RW-1:0] sum, shifted;
  logic signed [SAT_W-1:0] wide, clamped;
  logic signed [OUT_WIDTH-1:0] demod;
  fm_disc_history #(.WIDTH(WIDTH), .LAG(LAG)) u_hist (
    .clk(clk), .rst(rst), .clear(bus.clear_i), .valid(bus.valid_i),
    .re(bus.real_i), .im(bus.imag_i), .re_d(re_d), .im_d(im_d), .primed(primed)
  );
  always_comb begin
    sum = RW'(s2_p1) - RW'(s2_p2) + BIAS;
    shifted = sum >>> SHIFT;
    wide = SAT_W'(shifted);
    clamped = sat_to(wide, OUT_WIDTH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      valid <= 1'b0;
      sat <= 1'b0;
      demod <= '0;
      s1_a <= '0;
      s1_b <= '0;
      s1_ar <= '0;
      s1_br <= '0;
      s2_p1 <= '0;
      s2_p2 <= '0;
    end else begin
      s1_v <= bus.valid_i & primed & ~bus.clear_i;
      s2_v <= s1_v & ~bus.clear_i;
      valid <= s2_v & ~bus.clear_i;
      sat <= ~bus.clear_i & (sat | (s2_v & (clamped != wide)));
      if (bus.valid_i) begin
        s1_a <= bus.real_i;
        s1_b <= bus.imag_i;
        s1_ar <= re_d;
        s1_br <= im_d;
      end
      s2_p1 <= PW'(s1_b) * PW'(s1_ar);
      s2_p2 <= PW'(s1_a) * PW'(s1_br);
      if (s2_v && !bus.clear_i) demod <= clamped[OUT_WIDTH-1:0];
    end
  end
  assign bus.valid_o = valid;
  assign bus.demod_o = demod;
  assign bus.sat_o = sat;
endmodule

// File: tb/tb_fm_discriminator.sv
// tb_fm_discriminator: directed checks of LAG=1 and LAG=2 discriminators
module tb_fm_discriminator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic c1 = 1'b0, v1 = 1'b0, c2 = 1'b0, v2 = 1'b0;
  logic signed [15:0] r1 = '0, i1 = '0, r2 = '0, i2 = '0;
  fm_disc_if #(.WIDTH(16), .OUT_WIDTH(16)) b1 ();
  fm_disc_if #(.WIDTH(16), .OUT_WIDTH(16)) b2 ();
  assign b1.clear_i = c1;
  assign b1.valid_i = v1;
  assign b1.real_i = r1;
  assign b1.imag_i = i1;
  assign b2.clear_i = c2;
  assign b2.valid_i = v2;
  assign b2.real_i = r2;
  assign b2.imag_i = i2;
  fm_discriminator #(.WIDTH(16), .OUT_WIDTH(16), .LAG(1), .SHIFT(15)) u_l1 (.clk(clk), .rst(rst), .bus(b1));
  fm_discriminator #(.WIDTH(16), .OUT_WIDTH(16), .LAG(2), .SHIFT(15)) u_l2 (.clk(clk), .rst(rst), .bus(b2));
  logic signed [15:0] qv1[$], qv2[$];
  int qc1[$], qc2[$];
  always @(negedge clk) begin
    if (b1.valid_o) begin
      qv1.push_back(b1.demod_o);
      qc1.push_back(cyc);
    end
    if (b2.valid_o) begin
      qv2.push_back(b2.demod_o);
      qc2.push_back(cyc);
    end
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic put1(input int a, input int b, output int dc);
    v1 = 1'b1;
    r1 = 16'(a);
    i1 = 16'(b);
    dc = cyc;
    step();
    v1 = 1'b0;
  endtask
  task automatic put2(input int a, input int b, input int gap, output int dc);
    v2 = 1'b1;
    r2 = 16'(a);
    i2 = 16'(b);
    dc = cyc;
    step();
    v2 = 1'b0;
    step(gap);
  endtask
  task automatic clear1();
    c1 = 1'b1;
    step();
    c1 = 1'b0;
    qv1.delete();
    qc1.delete();
  endtask
  int d, d2, d3, d4;
  initial begin
    step(3);
    rst = 1'b0;
    step();
    chk("rst_valid", int'(b1.valid_o), 0);
    chk("rst_demod", int'(b1.demod_o), 0);
    chk("rst_sat", int'(b1.sat_o), 0);
    put1(16384, 0, d);
    put1(0, 16384, d);
    step(5);
    chk("t1_count", qv1.size(), 1);
    if (qv1.size() > 0) begin
      chk("t1_value", int'(qv1[0]), 8192);
      chk("t1_latency", qc1[0] - d, 3);
    end
    chk("t1_sat", int'(b1.sat_o), 0);
    clear1();
    put1(-32768, -32768, d);
    put1(32767, -32768, d);
    step(5);
    chk("t2_count", qv1.size(), 1);
    if (qv1.size() > 0) chk("t2_value", int'(qv1[0]), 32767);
    chk("t2_sat", int'(b1.sat_o), 1);
    step(4);
    chk("t2_sat_sticky", int'(b1.sat_o), 1);
    clear1();
    chk("t2_sat_cleared", int'(b1.sat_o), 0);
    chk("t2_demod_held", int'(b1.demod_o), 32767);
    put1(16384, 0, d);
    put1(0, 1, d);
    step(5);
    chk("t3_count", qv1.size(), 1);
`ifdef FM_DISC_ROUND_EN
    if (qv1.size() > 0) chk("t3_round", int'(qv1[0]), 1);
`else
    if (qv1.size() > 0) chk("t3_floor", int'(qv1[0]), 0);
`endif
    put2(16384, 0, 0, d);
    put2(0, 16384, 1, d);
    put2(0, 16384, 2, d2);
    put2(-8192, 0, 0, d3);
    put2(8192, -16384, 0, d4);
    step(5);
    chk("t4_count", qv2.size(), 3);
    if (qv2.size() == 3) begin
      chk("t4_val_s2", int'(qv2[0]), 8192);
      chk("t4_val_s3", int'(qv2[1]), 4096);
      chk("t4_val_s4", int'(qv2[2]), -4096);
      chk("t4_lat_s2", qc2[0] - d2, 3);
      chk("t4_lat_s3", qc2[1] - d3, 3);
      chk("t4_lat_s4", qc2[2] - d4, 3);
    end
    clear1();
    put1(-32768, -32768, d);
    put1(32767, -32768, d);
    c1 = 1'b1;
    v1 = 1'b1;
    r1 = 16'sd1;
    i1 = 16'sd1;
    step();
    c1 = 1'b0;
    v1 = 1'b0;
    put1(16384, 0, d);
    put1(0, 16384, d);
    put1(-8192, 0, d);
    step(5);
    chk("t5_count", qv1.size(), 2);
    if (qv1.size() == 2) begin
      chk("t5_val0", int'(qv1[0]), 8192);
      chk("t5_val1", int'(qv1[1]), 4096);
    end
    chk("t5_sat", int'(b1.sat_o), 0);
    qv1.delete();
    qc1.delete();
    put1(16384, 0, d);
    put1(0, 16384, d);
    v1 = 1'b1;
    r1 = -16'sd8192;
    i1 = 16'sd0;
    rst = 1'b1;
    step();
    v1 = 1'b0;
    rst = 1'b0;
    chk("t6_valid", int'(b1.valid_o), 0);
    chk("t6_demod", int'(b1.demod_o), 0);
    step(4);
    chk("t6_no_inflight", qv1.size(), 0);
    put1(16384, 0, d);
    step(4);
    chk("t6_priming", qv1.size(), 0);
    put1(0, 16384, d);
    step(5);
    chk("t6_count", qv1.size(), 1);
    if (qv1.size() > 0) chk("t6_value", int'(qv1[0]), 8192);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
